// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types and constants for the store buffer.
//   SB_DEPTH_DEFAULT : default entry count
//   SB_ADDR_W/DATA_W : widths the entry struct is built for; the top-level
//                      ADDR_W/DATA_W parameters must match these
//   sb_state_t       : RUN / FLUSH control states
//   sb_entry_t       : one buffered store {dword address, data}
package store_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_ADDR_W        = 64;
    localparam int SB_DATA_W        = 64;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sb_state_t;

    // Address is stored without the byte-offset bits [2:0].
    typedef struct packed {
        logic [SB_ADDR_W-4:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// store_buffer_fifo: circular storage for the store buffer.
//   clk, reset     : clock, synchronous active-high reset
//   push_i         : write push_entry_i at tail (caller guarantees !full)
//   pop_i          : retire head entry (caller guarantees !empty)
//   head_entry_o   : oldest entry
//   head_o         : head pointer, used by the forwarding search
//   count_o        : occupied entries, 0..DEPTH
//   entries_o      : raw storage array
//   valid_o        : per-slot occupancy mask
module store_buffer_fifo
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  sb_entry_t              push_entry_i,
    input  logic                   pop_i,
    output sb_entry_t              head_entry_o,
    output logic [PTR_W-1:0]       head_o,
    output logic [CNT_W-1:0]       count_o,
    output sb_entry_t [DEPTH-1:0]  entries_o,
    output logic [DEPTH-1:0]       valid_o
);

    sb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) tail_d = tail_q + PTR_W'(1);
        if (pop_i)  head_d = head_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Data storage needs no reset; occupancy is tracked by count/valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= push_entry_i;
    end

    // Slot i is live when its distance from head is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [PTR_W-1:0] off;
        assign off        = PTR_W'(i) - head_q;
        assign valid_o[i] = CNT_W'(off) < count_q;
    end

    assign head_entry_o = mem_q[head_q];
    assign head_o       = head_q;
    assign count_o      = count_q;
    assign entries_o    = mem_q;

endmodule

// File: rtl/store_buffer.sv
// store_buffer: write buffer between the core store path and data memory.
//   clk, reset            : clock, synchronous active-high reset
//   st_valid/st_ready     : store handshake; st_addr/st_data the store
//   ld_addr               : load lookup; ld_hit/ld_data forwarded result
//   mem_ready             : memory port granted this cycle
//   mem_wr/addr/data      : drain write toward data memory (head entry)
//   flush_req/flush_done  : level drain request / completion pulse
//   empty, full           : occupancy flags
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH_DEFAULT,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    input  logic              mem_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_state_t             state_q, state_d;
    logic                  push, pop;
    sb_entry_t             push_entry, head_entry;
    logic [PTR_W-1:0]      head;
    logic [CNT_W-1:0]      count;
    sb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic [PTR_W-1:0]      fwd_idx;

    // Byte offsets are meaningless for doubleword stores/lookups.
    logic unused_lsbs;
    assign unused_lsbs = ^{st_addr[2:0], ld_addr[2:0]};

    store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_entry_o (head_entry),
        .head_o       (head),
        .count_o      (count),
        .entries_o    (entries),
        .valid_o      (valid)
    );

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    // A same-cycle pop does not open a slot for a push while full.
    assign st_ready = !full && (state_q == RUN);
    assign push     = st_valid && st_ready;
    assign mem_wr   = !empty;
    assign pop      = mem_wr && mem_ready;

    assign push_entry.addr = st_addr[ADDR_W-1:3];
    assign push_entry.data = st_data;
    assign mem_addr        = {head_entry.addr, 3'b000};
    assign mem_data        = head_entry.data;

    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            RUN:     if (flush_req) state_d = FLUSH;
            FLUSH: begin
                if (empty) begin
                    flush_done = 1'b1;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PTR_W'(k);
            if (valid[fwd_idx] && entries[fwd_idx].addr == ld_addr[ADDR_W-1:3]) begin
                ld_hit  = 1'b1;
                ld_data = entries[fwd_idx].data;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, st_ready;
    logic [63:0] st_addr, st_data, ld_addr;
    logic        ld_hit;
    logic [63:0] ld_data;
    logic        mem_ready, mem_wr;
    logic [63:0] mem_addr, mem_data;
    logic        flush_req, flush_done, empty, full;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_ready(mem_ready), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
        .flush_req(flush_req), .flush_done(flush_done), .empty(empty), .full(full)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    int  n_chk = 0;
    int  n_err = 0;
    int  done_cnt = 0;
    wr_t exp_q[$];
    bit  exp_flush = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model + scoreboard, evaluated mid-cycle against the
    // inputs that will be sampled at the next rising edge.
    always @(negedge clk) begin
        bit          f_hit, e_ready, e_push, e_pop, e_done;
        logic [63:0] f_data;
        int          n;
        if (reset) begin
            exp_q.delete();
            exp_flush = 1'b0;
        end else begin
            n = exp_q.size();
            f_hit = 1'b0;
            f_data = '0;
            for (int i = 0; i < n; i++)
                if (exp_q[i].addr[63:3] == ld_addr[63:3]) begin
                    f_hit  = 1'b1;
                    f_data = exp_q[i].data;
                end
            e_ready = (n < DEPTH) && !exp_flush;
            e_done  = exp_flush && (n == 0);
            check("ld_hit", 64'(ld_hit), 64'(f_hit));
            check("ld_data", ld_data, f_data);
            check("st_ready", 64'(st_ready), 64'(e_ready));
            check("empty", 64'(empty), 64'(n == 0));
            check("full", 64'(full), 64'(n == DEPTH));
            check("mem_wr", 64'(mem_wr), 64'(n > 0));
            check("flush_done", 64'(flush_done), 64'(e_done));
            if (flush_done) done_cnt++;
            if (n > 0) begin
                check("mem_addr", mem_addr, exp_q[0].addr);
                check("mem_data", mem_data, exp_q[0].data);
            end
            e_push = st_valid && e_ready;
            e_pop  = (n > 0) && mem_ready;
            if (!exp_flush && flush_req) exp_flush = 1'b1;
            else if (e_done)             exp_flush = 1'b0;
            if (e_pop)  void'(exp_q.pop_front());
            if (e_push) exp_q.push_back('{addr: {st_addr[63:3], 3'b000}, data: st_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic [63:0] a, input logic [63:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        tick();
    endtask

    initial begin
        int base;
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_addr = '0; mem_ready = 1'b0; flush_req = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // fill to full with memory stalled; a fifth store must be refused
        push_store(64'h100, 64'hAAAA_AAAA_AAAA_AAAA);
        push_store(64'h108, 64'hBBBB_BBBB_BBBB_BBBB);
        push_store(64'h110, 64'hCCCC_CCCC_CCCC_CCCC);
        push_store(64'h118, 64'hDDDD_DDDD_DDDD_DDDD);
        push_store(64'h120, 64'hEEEE_EEEE_EEEE_EEEE);
        tick();
        check("full_after_4", 64'(full), 64'd1);
        st_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (6) tick();
        check("empty_after_drain", 64'(empty), 64'd1);
        mem_ready = 1'b0;

        // two stores to one dword; youngest must forward
        ld_addr = 64'h204;
        push_store(64'h200, 64'h1111_0000_0000_0001);
        push_store(64'h200, 64'h2222_0000_0000_0002);
        st_valid = 1'b0;
        tick();
        mem_ready = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b0;

        // full + pop in one cycle: push refused, taken next cycle
        push_store(64'h300, 64'h3);
        push_store(64'h308, 64'h4);
        push_store(64'h310, 64'h5);
        push_store(64'h318, 64'h6);
        st_addr = 64'h320; st_data = 64'h7; st_valid = 1'b1; mem_ready = 1'b1;
        tick();
        tick();
        st_valid = 1'b0;
        repeat (6) tick();
        mem_ready = 1'b0;

        // flush with 3 entries; store held pending during the drain
        push_store(64'h400, 64'h8);
        push_store(64'h408, 64'h9);
        push_store(64'h410, 64'hA);
        base = done_cnt;
        st_addr = 64'h500; st_data = 64'hB; st_valid = 1'b1;
        flush_req = 1'b1; mem_ready = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (6) tick();
        st_valid = 1'b0;
        check("flush_pulses", 64'(done_cnt - base), 64'd1);
        repeat (3) tick();

        // flush on an empty buffer
        base = done_cnt;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (3) tick();
        check("empty_flush_pulses", 64'(done_cnt - base), 64'd1);

        // held flush on empty buffer: one pulse per 2-cycle round trip
        base = done_cnt;
        flush_req = 1'b1;
        repeat (6) tick();
        flush_req = 1'b0;
        repeat (2) tick();
        check("held_flush_pulses", 64'(done_cnt - base), 64'd3);

        // random traffic against the model
        for (int c = 0; c < 300; c++) begin
            st_valid  = 1'($urandom_range(0, 1));
            st_addr   = 64'h400 + 64'($urandom_range(0, 3) * 8) + 64'($urandom_range(0, 7));
            st_data   = {$urandom, $urandom};
            ld_addr   = 64'h400 + 64'($urandom_range(0, 3) * 8) + 64'($urandom_range(0, 7));
            mem_ready = ($urandom_range(0, 2) != 0);
            flush_req = ($urandom_range(0, 15) == 0);
            tick();
        end
        st_valid = 1'b0; flush_req = 1'b0; mem_ready = 1'b1;
        repeat (8) tick();
        mem_ready = 1'b0;

        // reset with pending entries: they must never reach memory
        push_store(64'h600, 64'hC);
        push_store(64'h608, 64'hD);
        st_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("reset_empty", 64'(empty), 64'd1);
        check("reset_mem_wr", 64'(mem_wr), 64'd0);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
